// File: rtl/shmem_ring_pkg.sv
// Shared definitions for the shared-memory ring-buffer controller.
// Default geometry matches the 128x64 dual-port shared memory.
package shmem_ring_pkg;

  localparam int DEF_DATA_W     = 64;
  localparam int DEF_ADDR_W     = 7;
  localparam int DEF_DEPTH      = 2 ** DEF_ADDR_W;
  localparam int DEF_IRQ_THRESH = 64;

  // Ring pointer: one extra MSB tells full apart from empty.
  typedef logic [DEF_ADDR_W:0] ptr_t;

  // Occupancy: RAM words plus one in-flight read plus two skid entries.
  typedef logic [DEF_ADDR_W+1:0] level_t;

endpackage

// File: rtl/shmem_ring_skid.sv
// Two-entry valid/ready output FIFO that captures words returning from the
// memory read port. Its occupancy is exported so the issue logic never
// launches a read that would have nowhere to land.
module shmem_ring_skid #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [1:0]        count,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  logic [1:0]        count_r;
  logic [DATA_W-1:0] ent0_r;
  logic [DATA_W-1:0] ent1_r;
  logic              rd_s;

  assign rd_s  = rd_en && (count_r != 2'd0);
  assign count = count_r;
  assign valid = (count_r != 2'd0);
  assign data  = ent0_r;

  // Shift-register FIFO: entry 0 is always the head presented to the consumer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= 2'd0;
      ent0_r  <= '0;
      ent1_r  <= '0;
    end else if (flush) begin
      count_r <= 2'd0;
    end else begin
      case ({wr_en, rd_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            ent0_r <= wr_data;
          end else begin
            ent1_r <= wr_data;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          ent0_r  <= ent1_r;
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            ent0_r <= wr_data;
          end else begin
            ent0_r <= ent1_r;
            ent1_r <= wr_data;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

endmodule

// File: rtl/shmem_ring_ctrl.sv
// Ring-buffer controller driving both ports of the dual-port shared memory:
// port 1 writes pushed words, port 2 reads them back into a 2-entry skid FIFO.
// Optional feature macro: SHMEM_RING_IRQ_EN enables the level-threshold irq.
module shmem_ring_ctrl
  import shmem_ring_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
`ifdef SHMEM_RING_IRQ_EN
  ,
  parameter int IRQ_THRESH = DEF_IRQ_THRESH
`endif
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                push_valid,
  output logic                push_ready,
  input  logic [DATA_W-1:0]   push_data,
  output logic                pop_valid,
  input  logic                pop_ready,
  output logic [DATA_W-1:0]   pop_data,
  output logic [ADDR_W+1:0]   level,
  output logic [ADDR_W-1:0]   m1_address,
  output logic                m1_chipselect,
  output logic                m1_write,
  output logic [DATA_W/8-1:0] m1_byteenable,
  output logic [DATA_W-1:0]   m1_writedata,
  output logic [ADDR_W-1:0]   m2_address,
  output logic                m2_chipselect,
  input  logic [DATA_W-1:0]   m2_readdata,
  output logic                irq
);

  localparam logic [ADDR_W:0]   DEPTH_P = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W+1:0] LVL_ONE = {{(ADDR_W+1){1'b0}}, 1'b1};

  logic [ADDR_W:0]   wr_ptr_r;
  logic [ADDR_W:0]   rd_ptr_r;
  logic [ADDR_W:0]   ram_used_s;
  logic [ADDR_W+1:0] level_r;
  logic              rd_inflight_r;
  logic [1:0]        skid_count_s;
  logic [2:0]        occ_s;
  logic              full_s;
  logic              empty_s;
  logic              push_fire_s;
  logic              pop_fire_s;
  logic              issue_s;

  assign ram_used_s  = wr_ptr_r - rd_ptr_r;
  assign full_s      = (ram_used_s == DEPTH_P);
  assign empty_s     = (ram_used_s == '0);
  assign push_ready  = !full_s && !flush;
  assign push_fire_s = push_valid && push_ready;
  assign pop_fire_s  = pop_valid && pop_ready;

  // Skid slots committed after this cycle; a pop frees one slot this cycle.
  assign occ_s   = {1'b0, skid_count_s} + {2'b00, rd_inflight_r} - {2'b00, pop_fire_s};
  assign issue_s = !empty_s && !flush && (occ_s < 3'd2);

  // Write strobes are held low while reset is asserted even if the producer keeps pushing.
  assign m1_chipselect = push_fire_s && reset_n;
  assign m1_write      = push_fire_s && reset_n;
  assign m1_address    = wr_ptr_r[ADDR_W-1:0];
  assign m1_byteenable = '1;
  assign m1_writedata  = push_data;
  assign m2_chipselect = issue_s;
  assign m2_address    = rd_ptr_r[ADDR_W-1:0];
  assign level         = level_r;

  // Ring pointers and read-in-flight flag; flush drops the outstanding read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      rd_inflight_r <= 1'b0;
    end else if (flush) begin
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      rd_inflight_r <= 1'b0;
    end else begin
      if (push_fire_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (issue_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      rd_inflight_r <= issue_s;
    end
  end

  // Total words held: up on accepted push, down on accepted pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_r <= '0;
    end else if (flush) begin
      level_r <= '0;
    end else begin
      case ({push_fire_s, pop_fire_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  shmem_ring_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .wr_en   (rd_inflight_r),
    .wr_data (m2_readdata),
    .rd_en   (pop_fire_s),
    .count   (skid_count_s),
    .valid   (pop_valid),
    .data    (pop_data)
  );

`ifdef SHMEM_RING_IRQ_EN
  localparam logic [ADDR_W+1:0] THRESH_P = (ADDR_W+2)'(IRQ_THRESH);

  logic irq_r;

  // Threshold interrupt follows the registered level one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_r <= 1'b0;
    end else if (flush) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= (level_r >= THRESH_P);
    end
  end

  assign irq = irq_r;
`else
  assign irq = 1'b0;
`endif

endmodule
